// File: rtl/sc_velocity_control.sv
// Velocity selector FSM: dwell-timed up/down shifting between stop and three
// speeds, with a timed crash state. Outputs decode straight from the state register.
module sc_velocity_control #(
    parameter int unsigned ACCEL_DWELL = 25000000,
    parameter int unsigned BRAKE_DWELL = 12500000,
    parameter int unsigned CRASH_HOLD  = 100000000,
    parameter int unsigned CNT_WIDTH   = 27
) (
    input  logic       SC_VELOCITY_CONTROL_CLOCK_50,
    input  logic       SC_VELOCITY_CONTROL_RESET_InHigh,
    input  logic       SC_VELOCITY_CONTROL_RUN_InHigh,
    input  logic       SC_VELOCITY_CONTROL_ACCEL_InLow,
    input  logic       SC_VELOCITY_CONTROL_BRAKE_InLow,
    input  logic       SC_VELOCITY_CONTROL_CRASH_InHigh,
    output logic [1:0] SC_VELOCITY_CONTROL_SELECTIONVEL_OutBus,
    output logic       SC_VELOCITY_CONTROL_ENABLE_OutLow,
    output logic       SC_VELOCITY_CONTROL_CRASH_OutHigh
);

    localparam logic [2:0] ST_STOP  = 3'd0;
    localparam logic [2:0] ST_V1    = 3'd1;
    localparam logic [2:0] ST_V2    = 3'd2;
    localparam logic [2:0] ST_V3    = 3'd3;
    localparam logic [2:0] ST_CRASH = 3'd4;

    localparam logic [1:0] ACT_NONE  = 2'd0;
    localparam logic [1:0] ACT_BRAKE = 2'd1;
    localparam logic [1:0] ACT_ACCEL = 2'd2;

    localparam logic [CNT_WIDTH-1:0] ACCEL_LAST = CNT_WIDTH'(ACCEL_DWELL - 1);
    localparam logic [CNT_WIDTH-1:0] BRAKE_LAST = CNT_WIDTH'(BRAKE_DWELL - 1);
    localparam logic [CNT_WIDTH-1:0] CRASH_LAST = CNT_WIDTH'(CRASH_HOLD - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    logic                 clk;
    logic                 rst;
    logic [2:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_base;
    logic [1:0]           act_q, act_d, act_c;

    assign clk = SC_VELOCITY_CONTROL_CLOCK_50;
    assign rst = SC_VELOCITY_CONTROL_RESET_InHigh;

    // State, dwell counter and previous-action registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STOP;
            cnt_q   <= '0;
            act_q   <= ACT_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
        end
    end

    // Next-state, next-count and action tracking; brake wins over accel
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        act_d    = ACT_NONE;
        act_c    = ACT_NONE;
        cnt_base = '0;

        if (!SC_VELOCITY_CONTROL_BRAKE_InLow) begin
            act_c = ACT_BRAKE;
        end else if (!SC_VELOCITY_CONTROL_ACCEL_InLow) begin
            act_c = ACT_ACCEL;
        end

        // A change of action restarts the dwell from zero
        cnt_base = (act_c != act_q) ? '0 : cnt_q;

        if (!SC_VELOCITY_CONTROL_RUN_InHigh) begin
            state_d = ST_STOP;
        end else begin
            act_d = act_c;
            case (state_q)
                ST_CRASH: begin
                    if (cnt_q == CRASH_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_STOP, ST_V1, ST_V2, ST_V3: begin
                    if (SC_VELOCITY_CONTROL_CRASH_InHigh && (state_q != ST_STOP)) begin
                        state_d = ST_CRASH;
                    end else if (act_c == ACT_BRAKE) begin
                        // Braking in STOP saturates with the counter held at zero
                        if (state_q != ST_STOP) begin
                            if (cnt_base == BRAKE_LAST) begin
                                state_d = state_q - 3'd1;
                            end else begin
                                cnt_d = cnt_base + CNT_ONE;
                            end
                        end
                    end else if (act_c == ACT_ACCEL) begin
                        // Accelerating in V3 saturates with the counter held at zero
                        if (state_q != ST_V3) begin
                            if (cnt_base == ACCEL_LAST) begin
                                state_d = state_q + 3'd1;
                            end else begin
                                cnt_d = cnt_base + CNT_ONE;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_STOP;
                end
            endcase
        end
    end

    // Output decode from the state register
    always_comb begin
        SC_VELOCITY_CONTROL_SELECTIONVEL_OutBus = 2'b00;
        SC_VELOCITY_CONTROL_ENABLE_OutLow       = 1'b1;
        SC_VELOCITY_CONTROL_CRASH_OutHigh       = 1'b0;
        case (state_q)
            ST_V1: begin
                SC_VELOCITY_CONTROL_SELECTIONVEL_OutBus = 2'b01;
                SC_VELOCITY_CONTROL_ENABLE_OutLow       = 1'b0;
            end
            ST_V2: begin
                SC_VELOCITY_CONTROL_SELECTIONVEL_OutBus = 2'b10;
                SC_VELOCITY_CONTROL_ENABLE_OutLow       = 1'b0;
            end
            ST_V3: begin
                SC_VELOCITY_CONTROL_SELECTIONVEL_OutBus = 2'b11;
                SC_VELOCITY_CONTROL_ENABLE_OutLow       = 1'b0;
            end
            ST_CRASH: begin
                SC_VELOCITY_CONTROL_CRASH_OutHigh = 1'b1;
            end
            default: begin
                SC_VELOCITY_CONTROL_SELECTIONVEL_OutBus = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_sc_velocity_control.sv
// Directed bench for sc_velocity_control with short dwell parameters.
module tb_sc_velocity_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       accel_n;
    logic       brake_n;
    logic       crash_in;
    logic [1:0] sel;
    logic       en_n;
    logic       crash_out;

    int checks = 0;
    int errors = 0;

    sc_velocity_control #(
        .ACCEL_DWELL(4),
        .BRAKE_DWELL(2),
        .CRASH_HOLD (8),
        .CNT_WIDTH  (4)
    ) dut (
        .SC_VELOCITY_CONTROL_CLOCK_50          (clk),
        .SC_VELOCITY_CONTROL_RESET_InHigh      (rst),
        .SC_VELOCITY_CONTROL_RUN_InHigh        (run),
        .SC_VELOCITY_CONTROL_ACCEL_InLow       (accel_n),
        .SC_VELOCITY_CONTROL_BRAKE_InLow       (brake_n),
        .SC_VELOCITY_CONTROL_CRASH_InHigh      (crash_in),
        .SC_VELOCITY_CONTROL_SELECTIONVEL_OutBus(sel),
        .SC_VELOCITY_CONTROL_ENABLE_OutLow     (en_n),
        .SC_VELOCITY_CONTROL_CRASH_OutHigh     (crash_out)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] e_sel, input logic e_en, input logic e_cr);
        checks++;
        assert ({sel, en_n, crash_out} === {e_sel, e_en, e_cr})
        else begin
            errors++;
            $error("FAIL %s: observed sel=%b en_n=%b crash=%b expected sel=%b en_n=%b crash=%b",
                   tag, sel, en_n, crash_out, e_sel, e_en, e_cr);
        end
    endtask

    // Expected outputs for a pure velocity state
    task automatic check_vel(input string tag, input logic [1:0] e_sel);
        check(tag, e_sel, (e_sel == 2'b00), 1'b0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] exp_sel;

        rst = 1'b1; run = 1'b1; accel_n = 1'b1; brake_n = 1'b1; crash_in = 1'b0;
        #1;
        check("reset_async", 2'b00, 1'b1, 1'b0);
        tick(); tick();
        check("reset_held", 2'b00, 1'b1, 1'b0);
        rst = 1'b0;

        // Accel from STOP: V1 after edge 3, V2 after 7, V3 after 11
        accel_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_sel = (i >= 11) ? 2'b11 : (i >= 7) ? 2'b10 : (i >= 3) ? 2'b01 : 2'b00;
            check($sformatf("accel_ramp_%0d", i), exp_sel, (exp_sel == 2'b00), 1'b0);
        end
        repeat (3) tick();
        check_vel("accel_sat_v3", 2'b11);

        // V3: broken accel holds never shift
        repeat (3) tick();
        accel_n = 1'b1; tick();
        accel_n = 1'b0; repeat (3) tick();
        check_vel("v3_broken_accel", 2'b11);

        // Brake down to V1
        accel_n = 1'b1; brake_n = 1'b0;
        tick(); check_vel("brake_v3_mid", 2'b11);
        tick(); check_vel("brake_v3_to_v2", 2'b10);
        repeat (2) tick(); check_vel("brake_v2_to_v1", 2'b01);

        // V1: 3 accel, release, 3 accel -> no shift; the 4th consecutive shifts
        brake_n = 1'b1; accel_n = 1'b0;
        repeat (3) tick();
        accel_n = 1'b1; tick();
        accel_n = 1'b0; repeat (3) tick();
        check_vel("v1_broken_accel", 2'b01);
        tick(); check_vel("v1_restart_shift", 2'b10);

        // V2: both buttons -> brake wins
        brake_n = 1'b0;
        tick(); check_vel("both_mid", 2'b10);
        tick(); check_vel("both_to_v1", 2'b01);
        accel_n = 1'b1;
        tick(); check_vel("brake_v1_mid", 2'b01);
        tick(); check_vel("brake_v1_to_stop", 2'b00);
        repeat (3) tick(); check_vel("brake_stop_sat", 2'b00);

        // Back to V3, then crash with accel held throughout
        brake_n = 1'b1; accel_n = 1'b0;
        repeat (12) tick();
        check_vel("reach_v3", 2'b11);
        crash_in = 1'b1; tick(); crash_in = 1'b0;
        check("crash_enter", 2'b00, 1'b1, 1'b1);
        for (int i = 1; i < 8; i++) begin
            tick();
            check($sformatf("crash_hold_%0d", i), 2'b00, 1'b1, 1'b1);
        end
        tick();
        check("crash_exit", 2'b00, 1'b1, 1'b0);

        // Crash pulse in STOP is ignored
        accel_n = 1'b1;
        crash_in = 1'b1; tick(); crash_in = 1'b0;
        check("crash_in_stop", 2'b00, 1'b1, 1'b0);

        // V2 mid-brake dwell, RUN low for one cycle
        accel_n = 1'b0;
        repeat (8) tick();
        check_vel("reach_v2", 2'b10);
        accel_n = 1'b1; brake_n = 1'b0;
        tick(); check_vel("v2_brake_mid", 2'b10);
        run = 1'b0; tick(); run = 1'b1;
        check_vel("run_low_stop", 2'b00);
        tick(); check_vel("run_back_stop", 2'b00);

        // Reset asserted between edges in V3
        brake_n = 1'b1; accel_n = 1'b0;
        repeat (12) tick();
        check_vel("reach_v3_again", 2'b11);
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        check("reset_mid_v3", 2'b00, 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check_vel("post_reset_no_progress", 2'b00);
        tick();
        check_vel("post_reset_first_shift", 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_velocity_control.md
SC_VELOCITY_CONTROL -- requirements
Module: SC_VELOCITY_CONTROL

Interface
REQ-001 SHALL have parameter ACCEL_DWELL, default 25000000: consecutive accelerate-held cycles per upshift.
REQ-002 SHALL have parameter BRAKE_DWELL, default 12500000: consecutive brake-held cycles per downshift.
REQ-003 SHALL have parameter CRASH_HOLD, default 100000000: cycles spent in CRASH before returning to stop.
REQ-004 SHALL have parameter CNT_WIDTH, default 27: dwell counter width; it must hold max(dwell parameters)-1.
REQ-005 SC_VELOCITY_CONTROL_CLOCK_50  input  1  sole clock; all logic on rising edge.
REQ-006 SC_VELOCITY_CONTROL_RESET_InHigh  input  1  asynchronous, active-high reset.
REQ-007 SC_VELOCITY_CONTROL_RUN_InHigh  input  1  game active; low forces stop.
REQ-008 SC_VELOCITY_CONTROL_ACCEL_InLow  input  1  accelerate button, active-low, already debounced and synchronous.
REQ-009 SC_VELOCITY_CONTROL_BRAKE_InLow  input  1  brake button, active-low, already debounced and synchronous.
REQ-010 SC_VELOCITY_CONTROL_CRASH_InHigh  input  1  single-cycle collision pulse.
REQ-011 SC_VELOCITY_CONTROL_SELECTIONVEL_OutBus  output  2  velocity select to the velocity counter: 00 stop, 01 slow, 10 medium, 11 fast.
REQ-012 SC_VELOCITY_CONTROL_ENABLE_OutLow  output  1  velocity-counter enable, active-low; 0 only in V1/V2/V3.
REQ-013 SC_VELOCITY_CONTROL_CRASH_OutHigh  output  1  high while in CRASH.

Function
REQ-014 FSM states SHALL be STOP, V1, V2, V3, CRASH. Outputs SHALL decode directly from the state register, with no extra latency. Mapping: STOP=00/1/0, V1=01/0/0, V2=10/0/0, V3=11/0/0, CRASH=00/1/1 (SELECTIONVEL/ENABLE/CRASH).
REQ-015 Per-cycle action priority SHALL be: RUN low > CRASH pulse > brake held > accel held > none.
REQ-016 RUN low SHALL force state STOP and clear the dwell counter on the next edge, from any state including CRASH.
REQ-017 CRASH pulse in V1, V2 or V3 SHALL move the FSM to CRASH and clear the counter. CRASH pulses in STOP or CRASH SHALL be ignored.
REQ-018 In CRASH, the counter SHALL increment each cycle. On the edge where count==CRASH_HOLD-1, the FSM SHALL go to STOP and clear the counter. Buttons are ignored in CRASH.
REQ-019 Brake held in V1, V2 or V3 SHALL increment the counter. On the edge where count==BRAKE_DWELL-1, the FSM SHALL step down one state (V1->STOP) and clear the counter.
REQ-020 Accel held (brake not held) in STOP, V1 or V2 SHALL increment the counter. On the edge where count==ACCEL_DWELL-1, the FSM SHALL step up one state and clear the counter.
REQ-021 Saturation: accel in V3 and brake in STOP SHALL hold the state with the counter at 0.
REQ-022 No action (neither button, no crash, RUN high) SHALL hold the state and clear the counter; there is no coasting.
REQ-023 The counter SHALL clear on any cycle whose effective action (brake/accel/none) differs from the previous cycle's. A previous-action register SHALL exist for this.
REQ-024 Consequently, a transition SHALL require exactly DWELL consecutive cycles of the same action. Example: accel asserted from cycle 0 changes state on edge DWELL-1.
REQ-025 Counter arithmetic SHALL be unsigned CNT_WIDTH bits and SHALL never wrap. It compares for equality with DWELL-1 and clears on match.
REQ-026 Illegal state encodings SHALL recover to STOP on the next edge.

Reset
REQ-027 Reset high SHALL immediately, and asynchronously, set: state STOP, counter 0, previous-action none; SELECTIONVEL=00, ENABLE_OutLow=1, CRASH_OutHigh=0.
REQ-028 Reset deassertion SHALL take effect at the first clock edge after release. Reset asserted mid-dwell or mid-crash SHALL discard all progress.

Verification (bench params ACCEL_DWELL=4, BRAKE_DWELL=2, CRASH_HOLD=8, RUN=1)
REQ-029 Accel held 12 cycles from STOP -> SELECTIONVEL 01 after edge 3, 10 after edge 7, 11 after edge 11. ENABLE_OutLow falls with the first step. Further accel holds at 11.
REQ-030 In V3: accel 3 cycles, release 1 cycle, accel 3 cycles -> state stays V3. Repeat from V1 -> no upshift; counter restarts.
REQ-031 In V2: accel and brake both held 2 cycles -> V1 (brake priority). Brake 2 more cycles -> STOP; ENABLE_OutLow=1.
REQ-032 In V3, CRASH pulse -> CRASH_OutHigh=1 and SELECTIONVEL=00 next cycle, held 8 cycles with accel held throughout. Then STOP, CRASH_OutHigh=0. Crash pulse in STOP -> no change.
REQ-033 In V2 mid-brake-dwell, RUN=0 for 1 cycle -> STOP. Reset pulse asserted between edges in V3 -> outputs 00/1/0 before the next edge.
